fetch_unit: RTL and testbench

- Fetch stage of the 5-stage RISC-V pipeline. Owns the PC, the instruction-memory request handshake and the F/D pipeline register.
- It is the consumer of the hazard unit's Fo_stall, Do_stall and Do_flush, and of the E-stage redirect.
- It holds, bubbles or discards fetched instructions exactly as those controls demand.
- It tolerates variable-latency instruction memory with one outstanding request.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, the single-outstanding imem handshake and the F/D register.
// Honours hazard stalls/flushes and E-stage redirects, including redirects that land mid-request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Fi_stall,
  input  logic        Di_stall,
  input  logic        Di_flush,
  input  logic        Ei_redirect,
  input  logic [31:0] Ei_redirectPC,
  output logic        Fo_imemReq,
  output logic [31:0] Fo_imemAddr,
  input  logic        Fi_imemAck,
  input  logic [31:0] Fi_imemRdata,
  output logic        Fo_imemWait,
  output logic [31:0] Do_instr,
  output logic [31:0] Do_pc,
  output logic [31:0] Do_pcPlus4,
  output logic        Do_valid
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_pc4_q, fd_pc4_d;
  logic        fd_valid_q, fd_valid_d;

  logic        deliver;
  logic [31:0] dlv_instr;
  logic [31:0] dlv_pc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    deliver     = 1'b0;
    dlv_instr   = Fi_imemRdata;
    dlv_pc      = pc_q;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (Ei_redirect) pc_d = Ei_redirectPC;
      end
      StFetch: begin
        if (Ei_redirect) begin
          pc_d        = Ei_redirectPC;
          buf_valid_d = 1'b0;
          // Unacked request must still complete at its old address; its data is dropped.
          if (!Fi_imemAck) begin
            state_d     = StKill;
            kill_addr_d = pc_q;
          end
        end else if (Fi_imemAck) begin
          pc_d = pc_q + 32'd4;
          if (Fi_stall) begin
            buf_instr_d = Fi_imemRdata;
            buf_pc_d    = pc_q;
            buf_valid_d = 1'b1;
            state_d     = StHold;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      StHold: begin
        if (Ei_redirect) begin
          pc_d        = Ei_redirectPC;
          buf_valid_d = 1'b0;
          state_d     = StFetch;
        end else if (!Fi_stall && !Di_stall) begin
          deliver     = buf_valid_q;
          dlv_instr   = buf_instr_q;
          dlv_pc      = buf_pc_q;
          buf_valid_d = 1'b0;
          state_d     = StFetch;
        end
      end
      StKill: begin
        if (Ei_redirect) pc_d = Ei_redirectPC;
        if (Fi_imemAck) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats stall beats delivery; anything else is a bubble.
    fd_instr_d = NOP;
    fd_pc_d    = 32'h0;
    fd_pc4_d   = 32'h0;
    fd_valid_d = 1'b0;
    if (Di_flush) begin
      fd_instr_d = NOP;
    end else if (Di_stall) begin
      fd_instr_d = fd_instr_q;
      fd_pc_d    = fd_pc_q;
      fd_pc4_d   = fd_pc4_q;
      fd_valid_d = fd_valid_q;
    end else if (deliver) begin
      fd_instr_d = dlv_instr;
      fd_pc_d    = dlv_pc;
      fd_pc4_d   = dlv_pc + 32'd4;
      fd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      buf_instr_q <= NOP;
      buf_pc_q    <= 32'h0;
      buf_valid_q <= 1'b0;
      fd_instr_q  <= NOP;
      fd_pc_q     <= 32'h0;
      fd_pc4_q    <= 32'h0;
      fd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      fd_instr_q  <= fd_instr_d;
      fd_pc_q     <= fd_pc_d;
      fd_pc4_q    <= fd_pc4_d;
      fd_valid_q  <= fd_valid_d;
    end
  end

  assign Fo_imemReq  = (state_q == StFetch) || (state_q == StKill);
  assign Fo_imemAddr = (state_q == StKill) ? kill_addr_q : pc_q;
  assign Fo_imemWait = Fo_imemReq && !Fi_imemAck;
  assign Do_instr    = fd_instr_q;
  assign Do_pc       = fd_pc_q;
  assign Do_pcPlus4  = fd_pc4_q;
  assign Do_valid    = fd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table from reset, async-reset mid-request,
// then random hazards/acks against a transaction-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        Fi_stall, Di_stall, Di_flush, Ei_redirect;
  logic [31:0] Ei_redirectPC;
  logic        Fo_imemReq;
  logic [31:0] Fo_imemAddr;
  logic        Fi_imemAck;
  logic [31:0] Fi_imemRdata;
  logic        Fo_imemWait;
  logic [31:0] Do_instr, Do_pc, Do_pcPlus4;
  logic        Do_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign Fi_imemRdata = instr_of(Fo_imemAddr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .Fi_stall     (Fi_stall),
    .Di_stall     (Di_stall),
    .Di_flush     (Di_flush),
    .Ei_redirect  (Ei_redirect),
    .Ei_redirectPC(Ei_redirectPC),
    .Fo_imemReq   (Fo_imemReq),
    .Fo_imemAddr  (Fo_imemAddr),
    .Fi_imemAck   (Fi_imemAck),
    .Fi_imemRdata (Fi_imemRdata),
    .Fo_imemWait  (Fo_imemWait),
    .Do_instr     (Do_instr),
    .Do_pc        (Do_pc),
    .Do_pcPlus4   (Do_pcPlus4),
    .Do_valid     (Do_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic fs, input logic ds, input logic fl, input logic rd,
                       input logic [31:0] tgt, input logic ack);
    Fi_stall      = fs;
    Di_stall      = ds;
    Di_flush      = fl;
    Ei_redirect   = rd;
    Ei_redirectPC = tgt;
    Fi_imemAck    = ack;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'h0, Fo_imemReq}, 32'h0);
    chk({tag, "_addr"}, Fo_imemAddr, 32'h0);
    chk({tag, "_instr"}, Do_instr, NOP);
    chk({tag, "_pc"}, Do_pc, 32'h0);
    chk({tag, "_pc4"}, Do_pcPlus4, 32'h0);
    chk({tag, "_valid"}, {31'h0, Do_valid}, 32'h0);
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected during that cycle.
  typedef struct {
    logic        fs, ds, fl, rd;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic fs, input logic ds, input logic fl, input logic rd,
                              input logic [31:0] tgt, input logic ack, input logic req,
                              input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t r;
    r.fs = fs; r.ds = ds; r.fl = fl; r.rd = rd; r.tgt = tgt; r.ack = ack;
    r.req = req; r.addr = addr; r.v = v; r.pc = pc;
    return r;
  endfunction

  task automatic chk_outputs(input string tag, input logic req, input logic [31:0] addr,
                             input logic v, input logic [31:0] pc, input logic ack);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    chk({tag, "_req"}, {31'h0, Fo_imemReq}, {31'h0, req});
    if (req) chk({tag, "_addr"}, Fo_imemAddr, addr);
    chk({tag, "_wait"}, {31'h0, Fo_imemWait}, {31'h0, req & ~ack});
    chk({tag, "_valid"}, {31'h0, Do_valid}, {31'h0, v});
    chk({tag, "_pc"}, Do_pc, v ? pc : 32'h0);
    chk({tag, "_pc4"}, Do_pcPlus4, v ? p4 : 32'h0);
    chk({tag, "_instr"}, Do_instr, v ? instr_of(pc) : NOP);
  endtask

  // Reference model: request-level view of the fetch stage.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        m_started, m_inflight, m_doomed;
  logic [31:0] m_pc, m_req_addr;
  ent_t        m_held[$];
  logic        m_fv;
  logic [31:0] m_fpc;

  task automatic model_reset();
    m_started  = 1'b0;
    m_inflight = 1'b0;
    m_doomed   = 1'b0;
    m_pc       = 32'h0;
    m_req_addr = 32'h0;
    m_held.delete();
    m_fv       = 1'b0;
    m_fpc      = 32'h0;
  endtask

  task automatic model_issue();
    m_inflight = 1'b1;
    m_doomed   = 1'b0;
    m_req_addr = m_pc;
  endtask

  task automatic model_step();
    logic got;
    ent_t e;
    got = 1'b0;
    e.instr = 32'h0;
    e.pc = 32'h0;
    if (!m_started) begin
      m_started = 1'b1;
      if (Ei_redirect) m_pc = Ei_redirectPC;
      model_issue();
    end else if (m_held.size() != 0) begin
      if (Ei_redirect) begin
        m_held.delete();
        m_pc = Ei_redirectPC;
        model_issue();
      end else if (!Fi_stall && !Di_stall) begin
        e = m_held.pop_front();
        got = 1'b1;
        model_issue();
      end
    end else if (Ei_redirect) begin
      m_pc = Ei_redirectPC;
      if (Fi_imemAck) model_issue();
      else m_doomed = 1'b1;
    end else if (Fi_imemAck) begin
      if (m_doomed) begin
        model_issue();
      end else begin
        e.instr = instr_of(m_req_addr);
        e.pc    = m_req_addr;
        m_pc    = m_req_addr + 32'd4;
        if (Fi_stall) begin
          m_held.push_back(e);
          m_inflight = 1'b0;
        end else begin
          got = 1'b1;
          model_issue();
        end
      end
    end
    if (Di_flush) begin
      m_fv = 1'b0;
    end else if (!Di_stall) begin
      m_fv  = got;
      m_fpc = got ? e.pc : 32'h0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(0,0,0,0,32'h0,0, 0,32'h0,        0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h0,        0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h4,        1,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h8,        1,32'h4));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'hC,        1,32'h8));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h10,       1,32'hC));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h10,       0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h10,       0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h10,       0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h14,       1,32'h10));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h18,       1,32'h14));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h1C,       1,32'h18));
    tbl.push_back(mk(1,1,0,0,32'h0,1, 1,32'h20,       1,32'h1C));
    tbl.push_back(mk(1,1,0,0,32'h0,0, 0,32'h0,        1,32'h1C));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 0,32'h0,        1,32'h1C));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h24,       1,32'h20));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h28,       1,32'h24));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h2C,       1,32'h28));
    tbl.push_back(mk(0,0,1,1,32'h100,0, 1,32'h30,     1,32'h2C));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h30,       0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h30,       0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h100,      0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h100,      0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h104,      1,32'h100));
    tbl.push_back(mk(0,0,1,1,32'h200,1, 1,32'h108,    1,32'h104));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'h200,      0,32'h0));
    tbl.push_back(mk(0,0,1,1,32'hFFFF_FFFC,1, 1,32'h204, 1,32'h200));
    tbl.push_back(mk(0,0,0,0,32'h0,1, 1,32'hFFFF_FFFC, 0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,0, 1,32'h0,        1,32'hFFFF_FFFC));

    reset_x = 1'b0;
    apply(0, 0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 reset_x = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].fs, tbl[i].ds, tbl[i].fl, tbl[i].rd, tbl[i].tgt, tbl[i].ack);
      @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc,
                  tbl[i].ack);
      @(posedge clk);
      #1;
    end

    // Deliver PC 0 so F/D is non-trivial, then pull reset mid-request at 0x4.
    apply(0, 0, 0, 0, 32'h0, 1);
    @(posedge clk);
    #1 apply(0, 0, 0, 0, 32'h0, 0);
    #2;
    chk("prerst_req", {31'h0, Fo_imemReq}, 32'h1);
    chk("prerst_addr", Fo_imemAddr, 32'h4);
    chk("prerst_valid", {31'h0, Do_valid}, 32'h1);
    reset_x = 1'b0;
    #1;
    chk_reset_vals("async_rst");

    // Random phase.
    repeat (2) @(posedge clk);
    #1 reset_x = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic rd, fs;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 9) == 0);
      fs  = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      apply(fs, fs & $urandom_range(0, 1) == 1,
            rd ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
            rd, tgt, $urandom_range(0, 9) < 6);
      @(negedge clk);
      chk_outputs($sformatf("rnd%0d", n), m_inflight, m_req_addr, m_fv, m_fpc, Fi_imemAck);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
